uart_rx: RTL and testbench

Serial receiver that consumes the `uart_tx` line driven by `cpu_tiny` and returns the transmitted bytes. It decodes 8N1 frames into bytes and presents them on a one-entry ready/valid output. It flags framing errors and overruns. It is synthesizable, and `tb_tiny`-style benches instantiate it as the loop-back checker on the CPU's serial output.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 30 +++
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 serial link: frame constants, receiver
// state encoding and the bit-period helper used by both ends of the link.
package uart_pkg;

   localparam int DATA_BITS = 8;
   localparam int STATE_W   = 3;

   // Fixed 3-bit encodings so the transmitter and receiver agree on numbering
   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_START = 3'd1;
   localparam logic [STATE_W-1:0] ST_DATA  = 3'd2;
   localparam logic [STATE_W-1:0] ST_STOP  = 3'd3;
   localparam logic [STATE_W-1:0] ST_BREAK = 3'd4;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = ST_IDLE,
      START = ST_START,
      DATA  = ST_DATA,
      STOP  = ST_STOP,
      BREAK = ST_BREAK
   } rxState_t;

   // Whole clock cycles per bit; truncation is deliberate, the mid-bit
   // sampling absorbs the resulting small rate error.
   function automatic int calcClksPerBit(input int clkFreq, input int baud);
      return clkFreq / baud;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Double-flop synchronizer for bringing asynchronous signals into the clock
// domain. The reset value is a parameter so idle-high lines come out of
// reset already at their idle level and do not look like an edge.
module sync_2ff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   // First flop may go metastable; the second gives it a full cycle to settle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver. Decodes frames from an idle-high line into bytes,
// holds one byte on a ready/valid output and flags framing errors and
// overruns with single-cycle pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 115200
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun
);

   // Bit period must be at least 4 clocks for the half-bit start check to work
   localparam int CLKS_PER_BIT = calcClksPerBit(CLK_FREQ, BAUD);
   localparam int HALF         = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

   logic                 w_rxS;

   rxState_t             r_state;
   rxState_t             w_stateNext;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_cntNext;
   logic [2:0]           r_bitIdx;
   logic [2:0]           w_bitIdxNext;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shiftNext;
   logic                 w_goodByte;
   logic                 w_frameErr;

   sync_2ff #(
      .WIDTH     (1),
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (rx),
      .o_q   (w_rxS)
   );

   // Frame-tracking registers: state, bit-time counter, bit index, shifter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_bitIdx <= '0;
         r_shift  <= '0;
      end else begin
         r_state  <= w_stateNext;
         r_cnt    <= w_cntNext;
         r_bitIdx <= w_bitIdxNext;
         r_shift  <= w_shiftNext;
      end
   end

   // Next-state logic; the counter free-runs within a bit and is cleared at
   // each sample point so every later sample lands one full bit further on
   always_comb begin
      w_stateNext  = r_state;
      w_cntNext    = r_cnt + CNT_W'(1);
      w_bitIdxNext = r_bitIdx;
      w_shiftNext  = r_shift;
      w_goodByte   = 1'b0;
      w_frameErr   = 1'b0;
      case (r_state)
         IDLE: begin
            w_cntNext = '0;
            if (!w_rxS) begin
               w_stateNext = START;
            end
         end
         START: begin
            if (r_cnt == HALF_LAST) begin
               w_cntNext = '0;
               if (!w_rxS) begin
                  w_stateNext  = DATA;
                  w_bitIdxNext = '0;
               end else begin
                  w_stateNext = IDLE;
               end
            end
         end
         DATA: begin
            if (r_cnt == BIT_LAST) begin
               w_cntNext             = '0;
               w_shiftNext[r_bitIdx] = w_rxS;
               if (r_bitIdx == IDX_LAST) begin
                  w_stateNext = STOP;
               end else begin
                  w_bitIdxNext = r_bitIdx + 3'd1;
               end
            end
         end
         STOP: begin
            if (r_cnt == BIT_LAST) begin
               w_cntNext = '0;
               if (w_rxS) begin
                  w_goodByte  = 1'b1;
                  w_stateNext = IDLE;
               end else begin
                  w_frameErr  = 1'b1;
                  w_stateNext = BREAK;
               end
            end
         end
         BREAK: begin
            w_cntNext = '0;
            if (w_rxS) begin
               w_stateNext = IDLE;
            end
         end
         default: begin
            w_cntNext   = '0;
            w_stateNext = IDLE;
         end
      endcase
   end

   // One-entry output buffer; a pop and a load in the same cycle keep valid
   // high with the new byte, a load into a full unpopped buffer is dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= w_frameErr;
         overrun   <= w_goodByte && rx_valid && !rx_ready;
         if (w_goodByte && (!rx_valid || rx_ready)) begin
            rx_data  <= r_shift;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 10 clocks per bit. A frame-level model predicts the
// output buffer and pulses cycle by cycle; directed literal checks pin the
// latency, byte order and pulse counts.
module tb_uart_rx;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;

   int nChecks = 0;
   int nPass   = 0;
   int cyc     = 0;

   // A frame whose first start-bit cycle is N reaches the outputs at N+98:
   // 2 sync cycles, 5 to mid start bit, 9 bit times, 1 register stage
   localparam int LATENCY = 98;

   typedef struct {
      int         due;
      bit         good;
      logic [7:0] data;
   } evt_t;

   evt_t       evQ[$];
   logic [7:0] gotBytes[$];

   logic       mValid;
   logic [7:0] mData;
   logic       mFrameErr;
   logic       mOverrun;

   int         errCount  = 0;
   int         ovrCount  = 0;
   int         riseCount = 0;
   int         lastRiseCyc = -1;
   logic [7:0] lastRiseData = 8'h00;
   logic       prevValid = 1'b0;

   uart_rx #(
      .CLK_FREQ (1_000_000),
      .BAUD     (100_000)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   // 100 MHz nominal bench clock; only the cycle count matters
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle number, advanced on every rising edge
   always @(posedge clk) cyc = cyc + 1;

   // Single comparison point: counts every check and reports failures
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) begin
         nPass++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Hold the line at a level for n cycles; always returns just after a rising edge
   task automatic applyStimulus(input logic v, input int n);
      rx = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Send one 8N1 frame LSB first and tell the model what it should produce
   task automatic sendFrame(input logic [7:0] b, input logic stopBit, output int startCyc);
      evt_t e;
      startCyc = cyc;
      e.due    = cyc + LATENCY;
      e.good   = stopBit;
      e.data   = b;
      evQ.push_back(e);
      applyStimulus(1'b0, 10);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(b[i], 10);
      end
      applyStimulus(stopBit, 10);
   endtask

   // Model and compare on the falling edge: check this cycle, then predict next
   always @(negedge clk) begin
      if (!rst_n) begin
         mValid    = 1'b0;
         mData     = 8'h00;
         mFrameErr = 1'b0;
         mOverrun  = 1'b0;
      end
      checkOutput("rx_valid",  {31'd0, rx_valid},  {31'd0, mValid});
      checkOutput("rx_data",   {24'd0, rx_data},   {24'd0, mData});
      checkOutput("frame_err", {31'd0, frame_err}, {31'd0, mFrameErr});
      checkOutput("overrun",   {31'd0, overrun},   {31'd0, mOverrun});

      if (rx_valid && rx_ready) gotBytes.push_back(rx_data);
      if (frame_err) errCount++;
      if (overrun) ovrCount++;
      if (rx_valid && !prevValid) begin
         riseCount++;
         lastRiseCyc  = cyc;
         lastRiseData = rx_data;
      end
      prevValid = rx_valid;

      if (rst_n) begin
         logic popNow;
         popNow    = mValid && rx_ready;
         mFrameErr = 1'b0;
         mOverrun  = 1'b0;
         if (evQ.size() > 0 && evQ[0].due == cyc + 1) begin
            evt_t e;
            e = evQ.pop_front();
            if (!e.good) begin
               mFrameErr = 1'b1;
            end else if (!mValid || rx_ready) begin
               mValid = 1'b1;
               mData  = e.data;
            end else begin
               mOverrun = 1'b1;
            end
         end else if (popNow) begin
            mValid = 1'b0;
         end
      end
   end

   // Safety net so the bench always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit, got %0d checks expected completion", nChecks);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenario sequence
   initial begin
      int         s;
      int         savedRise;
      int         savedGot;
      logic [7:0] expBytes[7];

      expBytes[0] = 8'hA5; expBytes[1] = 8'h00; expBytes[2] = 8'hFF;
      expBytes[3] = 8'h55; expBytes[4] = 8'h11; expBytes[5] = 8'h7E;
      expBytes[6] = 8'hC3;

      rst_n    = 1'b0;
      rx       = 1'b1;
      rx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset rx_valid", {31'd0, rx_valid}, 32'd0);
      checkOutput("reset rx_data",  {24'd0, rx_data},  32'd0);
      rst_n = 1'b1;
      applyStimulus(1'b1, 20);

      $display("[TB] single byte 0xA5");
      sendFrame(8'hA5, 1'b1, s);
      applyStimulus(1'b1, 20);
      checkOutput("A5 valid cycle", lastRiseCyc, s + 98);
      checkOutput("A5 data",        {24'd0, lastRiseData}, 32'hA5);
      checkOutput("A5 rise count",  riseCount, 1);

      $display("[TB] back-to-back 0x00 0xFF 0x55");
      sendFrame(8'h00, 1'b1, s);
      sendFrame(8'hFF, 1'b1, s);
      sendFrame(8'h55, 1'b1, s);
      applyStimulus(1'b1, 20);
      checkOutput("b2b byte count", gotBytes.size(), 4);

      $display("[TB] overrun 0x11 then 0x22");
      rx_ready = 1'b0;
      sendFrame(8'h11, 1'b1, s);
      sendFrame(8'h22, 1'b1, s);
      applyStimulus(1'b1, 20);
      checkOutput("ovr held valid", {31'd0, rx_valid}, 32'd1);
      checkOutput("ovr held data",  {24'd0, rx_data},  32'h11);
      checkOutput("ovr pulses",     ovrCount, 1);
      rx_ready = 1'b1;
      @(negedge clk);
      checkOutput("ovr pop cycle valid", {31'd0, rx_valid}, 32'd1);
      @(negedge clk);
      checkOutput("ovr after pop valid", {31'd0, rx_valid}, 32'd0);
      @(posedge clk);
      #1;

      $display("[TB] framing error 0x3C then 0x7E");
      savedRise = riseCount;
      sendFrame(8'h3C, 1'b0, s);
      applyStimulus(1'b0, 30);
      applyStimulus(1'b1, 30);
      checkOutput("ferr pulses",     errCount, 1);
      checkOutput("ferr no valid",   riseCount, savedRise);
      sendFrame(8'h7E, 1'b1, s);
      applyStimulus(1'b1, 20);
      checkOutput("7E data", {24'd0, lastRiseData}, 32'h7E);

      $display("[TB] glitch");
      savedRise = riseCount;
      applyStimulus(1'b0, 2);
      applyStimulus(1'b1, 30);
      checkOutput("glitch no valid", riseCount, savedRise);
      checkOutput("glitch no ferr",  errCount, 1);

      $display("[TB] reset mid-frame");
      savedGot = gotBytes.size();
      applyStimulus(1'b0, 10);
      for (int i = 0; i < 4; i++) applyStimulus(i[0], 10);
      applyStimulus(1'b1, 5);
      rst_n = 1'b0;
      rx    = 1'b1;
      #1;
      checkOutput("async reset rx_data",   {24'd0, rx_data},   32'd0);
      checkOutput("async reset rx_valid",  {31'd0, rx_valid},  32'd0);
      checkOutput("async reset frame_err", {31'd0, frame_err}, 32'd0);
      checkOutput("async reset overrun",   {31'd0, overrun},   32'd0);
      applyStimulus(1'b1, 3);
      rst_n = 1'b1;
      applyStimulus(1'b1, 120);
      checkOutput("post reset no bytes", gotBytes.size(), savedGot);
      checkOutput("post reset ferr",     errCount, 1);
      checkOutput("post reset ovr",      ovrCount, 1);

      $display("[TB] byte 0xC3 after reset");
      sendFrame(8'hC3, 1'b1, s);
      applyStimulus(1'b1, 20);
      checkOutput("C3 valid cycle", lastRiseCyc, s + 98);

      checkOutput("total bytes", gotBytes.size(), 7);
      for (int i = 0; i < 7; i++) begin
         if (i < gotBytes.size()) begin
            checkOutput($sformatf("byte %0d", i), {24'd0, gotBytes[i]}, {24'd0, expBytes[i]});
         end
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
